// File: rtl/spi_bridge_pkg.sv
// Shared types and helpers for the SPI-to-register-bus bridge.
// Mode constants are {CPOL, CPHA}.
package spi_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    WDATA,
    RDATA
  } state_e;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  // Data is captured on the rising sclk edge exactly when CPOL == CPHA.
  function automatic logic sample_on_rise(
    input logic cpol,
    input logic cpha
  );
    return cpol == cpha;
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronises the asynchronous SPI pins into clk and derives
// sclk rise/fall and cs_n fall events.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit SCLK_IDLE   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_n_s,
  output logic cs_fall,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] sclk_q, sclk_d;
  logic [SYNC_STAGES-1:0] cs_q, cs_d;
  logic [SYNC_STAGES-1:0] mosi_q, mosi_d;
  logic sclk_prev_q, sclk_prev_d;
  logic cs_prev_q, cs_prev_d;
  logic sclk_s;

  always_comb begin
    sclk_d      = {sclk_q[SYNC_STAGES-2:0], sclk};
    cs_d        = {cs_q[SYNC_STAGES-2:0], cs_n};
    mosi_d      = {mosi_q[SYNC_STAGES-2:0], mosi};
    sclk_prev_d = sclk_q[SYNC_STAGES-1];
    cs_prev_d   = cs_q[SYNC_STAGES-1];
  end

  // cs_n resets low so a frame already in flight never looks armed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q      <= {SYNC_STAGES{SCLK_IDLE}};
      cs_q        <= '0;
      mosi_q      <= '0;
      sclk_prev_q <= SCLK_IDLE;
      cs_prev_q   <= 1'b0;
    end else begin
      sclk_q      <= sclk_d;
      cs_q        <= cs_d;
      mosi_q      <= mosi_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
    end
  end

  assign sclk_s    = sclk_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_n_s    = cs_q[SYNC_STAGES-1];
  assign cs_fall   = ~cs_n_s & cs_prev_q;
  assign mosi_s    = mosi_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI slave to single-cycle register bus bridge with burst
// auto-increment, all four SPI modes and parametrised widths.
module spi_reg_bridge
  import spi_bridge_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              frame_abort
);

  localparam int HDR_W = ADDR_W + 1;
  localparam int SR_W  = (HDR_W > DATA_W) ? HDR_W : DATA_W;
  localparam int CNT_W = $clog2(SR_W + 1);
  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_W - 1);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(DATA_W - 1);
  localparam bit SMP_RISE =
    sample_on_rise(CPOL != 0, CPHA != 0);

  logic sclk_rise, sclk_fall, cs_n_s, cs_fall, mosi_s;
  logic smp, shf;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic miso_q, miso_d;
  logic we_q, we_d;
  logic re_q, re_d;
  logic ld_q, ld_d;
  logic abort_q, abort_d;
  logic armed_q, armed_d;

  spi_pin_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .SCLK_IDLE  (CPOL != 0)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall),
    .cs_n_s   (cs_n_s),
    .cs_fall  (cs_fall),
    .mosi_s   (mosi_s)
  );

  assign smp = SMP_RISE ? sclk_rise : sclk_fall;
  assign shf = SMP_RISE ? sclk_fall : sclk_rise;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    tx_d    = tx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    miso_d  = miso_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    ld_d    = 1'b0;
    abort_d = 1'b0;
    armed_d = armed_q | cs_n_s;
    if (we_q) addr_d = addr_q + 1'b1;
    if (cs_n_s) begin
      if (state_q != IDLE && cnt_q != '0)
        abort_d = 1'b1;
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cs_fall && armed_q) begin
            state_d = HDR;
            cnt_d   = '0;
          end
        end
        HDR: begin
          if (smp) begin
            sr_d  = SR_W'({sr_q, mosi_s});
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == HDR_LAST) begin
              cnt_d  = '0;
              addr_d = sr_d[HDR_W-1:1];
              if (sr_d[0]) begin
                state_d = WDATA;
              end else begin
                state_d = RDATA;
                re_d    = 1'b1;
              end
            end
          end
        end
        WDATA: begin
          if (smp) begin
            sr_d  = SR_W'({sr_q, mosi_s});
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == WORD_LAST) begin
              cnt_d   = '0;
              wdata_d = sr_d[DATA_W-1:0];
              we_d    = 1'b1;
            end
          end
        end
        RDATA: begin
          ld_d = re_q;
          // CPHA=0 owns the line from the load, so the shift
          // edge closing a word must not advance the next one.
          if (ld_q) begin
            if (CPHA == 0) begin
              miso_d = reg_rdata[DATA_W-1];
              tx_d   = reg_rdata << 1;
            end else begin
              tx_d = reg_rdata;
            end
          end else if (shf && (CPHA != 0 || cnt_q != '0)) begin
            miso_d = tx_q[DATA_W-1];
            tx_d   = tx_q << 1;
          end
          if (smp) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == WORD_LAST) begin
              cnt_d  = '0;
              addr_d = addr_q + 1'b1;
              re_d   = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (state_d != RDATA) miso_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      tx_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      miso_q  <= 1'b0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      ld_q    <= 1'b0;
      abort_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      tx_q    <= tx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      miso_q  <= miso_d;
      we_q    <= we_d;
      re_q    <= re_d;
      ld_q    <= ld_d;
      abort_q <= abort_d;
      armed_q <= armed_d;
    end
  end

  assign miso        = miso_q;
  assign miso_oe     = (state_q == RDATA);
  assign reg_addr    = addr_q;
  assign reg_wdata   = wdata_q;
  assign reg_we      = we_q;
  assign reg_re      = re_q;
  assign frame_abort = abort_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench: four bridge instances (modes 0/3 at 8-bit,
// modes 1/2 at 16-bit) driven by one bit-banged SPI master.
module tb_spi_reg_bridge;

  localparam int H = 10;
  localparam logic [3:0] CPOL_V = 4'b1010;
  localparam logic [3:0] CPHA_V = 4'b0110;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] sel = 2'd0;
  logic sclk_g = 1'b0;
  logic cs_g = 1'b1;
  logic mosi_g = 1'b0;

  logic [3:0] sclk_v, cs_v;
  logic [3:0] miso_v, oe_v, we_v, re_v, ab_v;
  logic [6:0] a0, a1;
  logic [14:0] a2, a3;
  logic [7:0] w0, w1, rd8;
  logic [15:0] w2, w3, rd16;

  logic m_we, m_re, m_ab, m_miso, m_oe;
  logic [15:0] m_addr, m_wd;

  logic [15:0] we_a[$];
  logic [15:0] we_d[$];
  logic [15:0] re_a[$];
  int n_abort = 0;
  int n_both = 0;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign rd16 = 16'h0000;

  always_comb begin
    sclk_v = CPOL_V;
    cs_v   = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      if (sel == k) begin
        sclk_v[k] = sclk_g;
        cs_v[k]   = cs_g;
      end
    end
  end

  spi_reg_bridge #(
    .DATA_W(8), .ADDR_W(7), .CPOL(0), .CPHA(0)
  ) u_m0 (
    .clk(clk), .rst(rst), .sclk(sclk_v[0]),
    .cs_n(cs_v[0]), .mosi(mosi_g),
    .miso(miso_v[0]), .miso_oe(oe_v[0]),
    .reg_addr(a0), .reg_wdata(w0),
    .reg_we(we_v[0]), .reg_re(re_v[0]),
    .reg_rdata(rd8), .frame_abort(ab_v[0])
  );

  spi_reg_bridge #(
    .DATA_W(8), .ADDR_W(7), .CPOL(1), .CPHA(1)
  ) u_m3 (
    .clk(clk), .rst(rst), .sclk(sclk_v[1]),
    .cs_n(cs_v[1]), .mosi(mosi_g),
    .miso(miso_v[1]), .miso_oe(oe_v[1]),
    .reg_addr(a1), .reg_wdata(w1),
    .reg_we(we_v[1]), .reg_re(re_v[1]),
    .reg_rdata(rd8), .frame_abort(ab_v[1])
  );

  spi_reg_bridge #(
    .DATA_W(16), .ADDR_W(15), .CPOL(0), .CPHA(1)
  ) u_m1 (
    .clk(clk), .rst(rst), .sclk(sclk_v[2]),
    .cs_n(cs_v[2]), .mosi(mosi_g),
    .miso(miso_v[2]), .miso_oe(oe_v[2]),
    .reg_addr(a2), .reg_wdata(w2),
    .reg_we(we_v[2]), .reg_re(re_v[2]),
    .reg_rdata(rd16), .frame_abort(ab_v[2])
  );

  spi_reg_bridge #(
    .DATA_W(16), .ADDR_W(15), .CPOL(1), .CPHA(0)
  ) u_m2 (
    .clk(clk), .rst(rst), .sclk(sclk_v[3]),
    .cs_n(cs_v[3]), .mosi(mosi_g),
    .miso(miso_v[3]), .miso_oe(oe_v[3]),
    .reg_addr(a3), .reg_wdata(w3),
    .reg_we(we_v[3]), .reg_re(re_v[3]),
    .reg_rdata(rd16), .frame_abort(ab_v[3])
  );

  always_comb begin
    m_we   = we_v[sel];
    m_re   = re_v[sel];
    m_ab   = ab_v[sel];
    m_miso = miso_v[sel];
    m_oe   = oe_v[sel];
    unique case (sel)
      2'd0: begin m_addr = 16'(a0); m_wd = 16'(w0); end
      2'd1: begin m_addr = 16'(a1); m_wd = 16'(w1); end
      2'd2: begin m_addr = 16'(a2); m_wd = w2; end
      default: begin m_addr = 16'(a3); m_wd = w3; end
    endcase
  end

  function automatic logic [7:0] rd_val(input logic [15:0] a);
    case (a)
      16'h0010: return 8'h3C;
      16'h0011: return 8'hC3;
      default:  return 8'h5A;
    endcase
  endfunction

  // Register file with one-clk read latency.
  always @(posedge clk) begin
    if (rst) rd8 <= 8'h00;
    else if (m_re) rd8 <= rd_val(m_addr);
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (m_we) begin
        we_a.push_back(m_addr);
        we_d.push_back(m_wd);
      end
      if (m_re) re_a.push_back(m_addr);
      if (m_ab) n_abort++;
      if (m_we && m_re) n_both++;
    end
  end

  task automatic check(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start(input logic [1:0] s);
    sel    = s;
    sclk_g = CPOL_V[s];
    cs_g   = 1'b1;
    mosi_g = 1'b0;
    repeat (20) @(negedge clk);
    cs_g = 1'b0;
    repeat (H) @(negedge clk);
  endtask

  task automatic xfer(
    input  logic [63:0] tx,
    input  int          n,
    output logic [63:0] rx
  );
    logic pol, pha;
    pol = CPOL_V[sel];
    pha = CPHA_V[sel];
    rx  = '0;
    for (int i = 0; i < n; i++) begin
      if (!pha) begin
        mosi_g = tx[n-1-i];
        repeat (H) @(negedge clk);
        sclk_g = ~pol;
        rx = {rx[62:0], m_miso};
        repeat (H) @(negedge clk);
        sclk_g = pol;
      end else begin
        sclk_g = ~pol;
        mosi_g = tx[n-1-i];
        repeat (H) @(negedge clk);
        sclk_g = pol;
        rx = {rx[62:0], m_miso};
        repeat (H) @(negedge clk);
      end
    end
  endtask

  task automatic stop();
    repeat (H) @(negedge clk);
    cs_g = 1'b1;
    repeat (4 * H) @(negedge clk);
  endtask

  initial begin
    logic [63:0] rx;
    int s_we, s_re, s_ab;

    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_addr", 32'(a0), 32'h0);
    check("rst_wdata", 32'(w0), 32'h0);
    check("rst_we", 32'(we_v[0]), 32'h0);
    check("rst_re", 32'(re_v[0]), 32'h0);
    check("rst_oe", 32'(oe_v[0]), 32'h0);
    check("rst_miso", 32'(miso_v[0]), 32'h0);
    check("rst_abort", 32'(ab_v[0]), 32'h0);

    // 1: mode 0 single write
    s_we = we_a.size(); s_ab = n_abort;
    start(2'd0);
    xfer({48'h0, 8'h85, 8'hA5}, 16, rx);
    stop();
    check("t1_we_n", we_a.size() - s_we, 1);
    check("t1_addr", we_a[s_we], 32'h42);
    check("t1_wdata", we_d[s_we], 32'hA5);
    check("t1_abort", n_abort - s_ab, 0);

    // 2: mode 3 two-word read burst with prefetch
    s_we = we_a.size(); s_re = re_a.size();
    start(2'd1);
    xfer({40'h0, 8'h20, 16'h0000}, 24, rx);
    check("t2_rx", rx[15:0], 32'h3CC3);
    check("t2_oe_on", 32'(m_oe), 32'h1);
    stop();
    check("t2_oe_off", 32'(m_oe), 32'h0);
    check("t2_miso_off", 32'(m_miso), 32'h0);
    check("t2_re_n", re_a.size() - s_re, 3);
    check("t2_re0", re_a[s_re], 32'h10);
    check("t2_re1", re_a[s_re + 1], 32'h11);
    check("t2_re2", re_a[s_re + 2], 32'h12);
    check("t2_we_n", we_a.size() - s_we, 0);

    // 3: burst write wrapping past 0x7F
    s_we = we_a.size();
    start(2'd0);
    xfer({32'h0, 8'hFF, 8'h11, 8'h22, 8'h33}, 32, rx);
    stop();
    check("t3_we_n", we_a.size() - s_we, 3);
    check("t3_a0", we_a[s_we], 32'h7F);
    check("t3_a1", we_a[s_we + 1], 32'h00);
    check("t3_a2", we_a[s_we + 2], 32'h01);
    check("t3_d0", we_d[s_we], 32'h11);
    check("t3_d1", we_d[s_we + 1], 32'h22);
    check("t3_d2", we_d[s_we + 2], 32'h33);

    // 4: abort after 5 data bits, then a clean frame
    s_we = we_a.size(); s_ab = n_abort;
    start(2'd0);
    xfer({51'h0, 8'h41, 5'b10110}, 13, rx);
    stop();
    check("t4_we_n", we_a.size() - s_we, 0);
    check("t4_abort", n_abort - s_ab, 1);
    s_we = we_a.size(); s_ab = n_abort;
    start(2'd0);
    xfer({48'h0, 8'h0B, 8'h3C}, 16, rx);
    stop();
    check("t4_next_n", we_a.size() - s_we, 1);
    check("t4_next_a", we_a[s_we], 32'h05);
    check("t4_next_d", we_d[s_we], 32'h3C);
    check("t4_next_ab", n_abort - s_ab, 0);

    // 5: reset mid-frame with cs_n held low
    s_we = we_a.size(); s_ab = n_abort;
    start(2'd0);
    xfer({53'h0, 8'h85, 3'b101}, 11, rx);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t5_rst_we", 32'(we_v[0]), 32'h0);
    check("t5_rst_addr", 32'(a0), 32'h0);
    check("t5_rst_wd", 32'(w0), 32'h0);
    xfer({48'h0, 5'b00101, 8'hFF, 3'b011}, 16, rx);
    stop();
    check("t5_ign_we", we_a.size() - s_we, 0);
    check("t5_ign_ab", n_abort - s_ab, 0);
    s_we = we_a.size();
    start(2'd0);
    xfer({48'h0, 8'h67, 8'h96}, 16, rx);
    stop();
    check("t5_we_n", we_a.size() - s_we, 1);
    check("t5_addr", we_a[s_we], 32'h33);
    check("t5_wdata", we_d[s_we], 32'h96);

    // 6: 16-bit data, 15-bit address, modes 1 and 2
    for (int m = 2; m < 4; m++) begin
      s_we = we_a.size(); s_ab = n_abort;
      start(2'(m));
      xfer({32'h0, 16'h2469, 16'hBEEF}, 32, rx);
      stop();
      check($sformatf("t6_m%0d_we_n", m - 1),
            we_a.size() - s_we, 1);
      check($sformatf("t6_m%0d_addr", m - 1),
            we_a[s_we], 32'h1234);
      check($sformatf("t6_m%0d_wdata", m - 1),
            we_d[s_we], 32'hBEEF);
      check($sformatf("t6_m%0d_abort", m - 1),
            n_abort - s_ab, 0);
    end

    check("we_re_overlap", n_both, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
